// File: rtl/rr_arbiter.sv
// rr_arbiter: four-host (m,s,t,e) round-robin arbiter onto one shared slave bus.
// Define ARB_TIMEOUT_EN to add a BUSY watchdog that returns 32'hDEAD_BEEF.
module rr_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int BE_W    = DATA_W / 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mcpu,
    input  logic [ADDR_W-1:0] maddr,
    input  logic              mrd,
    input  logic              mwr,
    input  logic [BE_W-1:0]   mbe,
    input  logic [DATA_W-1:0] mdwr,
    output logic [DATA_W-1:0] mdrd,
    output logic              mack,
    input  logic              scpu,
    input  logic [ADDR_W-1:0] saddr,
    input  logic              srd,
    input  logic              swr,
    input  logic [BE_W-1:0]   sbe,
    input  logic [DATA_W-1:0] sdwr,
    output logic [DATA_W-1:0] sdrd,
    output logic              sack,
    input  logic              tcpu,
    input  logic [ADDR_W-1:0] taddr,
    input  logic              trd,
    input  logic              twr,
    input  logic [BE_W-1:0]   tbe,
    input  logic [DATA_W-1:0] tdwr,
    output logic [DATA_W-1:0] tdrd,
    output logic              tack,
    input  logic              ecpu,
    input  logic [ADDR_W-1:0] eaddr,
    input  logic              erd,
    input  logic              ewr,
    input  logic [BE_W-1:0]   ebe,
    input  logic [DATA_W-1:0] edwr,
    output logic [DATA_W-1:0] edrd,
    output logic              eack,
    output logic [ADDR_W-1:0] add_bus,
    output logic [BE_W-1:0]   byte_en,
    output logic              wr_bus,
    output logic              rd_bus,
    output logic [DATA_W-1:0] data_bus_wr,
    input  logic [DATA_W-1:0] data_bus_rd,
    input  logic              ack_bus,
    output logic              cpu_bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_g, r_p, w_g_nxt, w_p_nxt, w_idx;
    logic              w_found, w_busy, w_to, w_end;
    logic [3:0]        w_cpu, w_rd, w_wr, w_req, w_sel;
    logic [ADDR_W-1:0] w_addr [4];
    logic [BE_W-1:0]   w_be [4];
    logic [DATA_W-1:0] w_dwr [4];
    logic [DATA_W-1:0] w_drd;

    assign w_cpu = {ecpu, tcpu, scpu, mcpu};
    assign w_rd  = {erd, trd, srd, mrd};
    assign w_wr  = {ewr, twr, swr, mwr};
    assign w_req = w_cpu & (w_rd | w_wr);

    assign w_addr = '{maddr, saddr, taddr, eaddr};
    assign w_be   = '{mbe, sbe, tbe, ebe};
    assign w_dwr  = '{mdwr, sdwr, tdwr, edwr};

    assign w_busy = (r_state == BUSY);

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (!w_busy)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 8'd1;
    end

    assign w_to = w_busy && w_cpu[r_g] && !ack_bus && (r_cnt == 8'(TIMEOUT));
`else
    logic w_unused_to;
    assign w_unused_to = |8'(TIMEOUT);
    assign w_to        = 1'b0;
`endif

    // Transfer ends on ack, watchdog expiry, or the owner dropping its session.
    assign w_end = ack_bus || w_to || !w_cpu[r_g];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_g     <= 2'd0;
            r_p     <= 2'd3;
        end else begin
            r_state <= w_state_nxt;
            r_g     <= w_g_nxt;
            r_p     <= w_p_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_g_nxt     = r_g;
        w_p_nxt     = r_p;
        w_found     = 1'b0;
        w_idx       = r_p;
        unique case (r_state)
            IDLE: begin
                for (int k = 1; k <= 4; k++) begin
                    w_idx = r_p + 2'(k);
                    if (!w_found && w_req[w_idx]) begin
                        w_found     = 1'b1;
                        w_g_nxt     = w_idx;
                        w_state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (w_end) begin
                    w_p_nxt     = r_g;
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    assign cpu_bus     = w_busy;
    assign add_bus     = w_busy ? w_addr[r_g] : '0;
    assign byte_en     = w_busy ? w_be[r_g] : '0;
    assign data_bus_wr = w_busy ? w_dwr[r_g] : '0;
    assign rd_bus      = w_busy & w_cpu[r_g] & w_rd[r_g];
    assign wr_bus      = w_busy & w_cpu[r_g] & w_wr[r_g] & ~w_rd[r_g];

    assign w_drd = w_to ? DATA_W'(32'hDEAD_BEEF) : data_bus_rd;

    for (genvar i = 0; i < 4; i++) begin : g_sel
        assign w_sel[i] = w_busy && (r_g == 2'(i));
    end

    assign mack = w_sel[0] & (ack_bus | w_to);
    assign sack = w_sel[1] & (ack_bus | w_to);
    assign tack = w_sel[2] & (ack_bus | w_to);
    assign eack = w_sel[3] & (ack_bus | w_to);
    assign mdrd = w_sel[0] ? w_drd : '0;
    assign sdrd = w_sel[1] ? w_drd : '0;
    assign tdrd = w_sel[2] ? w_drd : '0;
    assign edrd = w_sel[3] ? w_drd : '0;
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed vectors plus randomized traffic against a
// round-robin reference model for rr_arbiter.
`timescale 1ns/1ps
module tb_rr_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          h_cpu [4];
    logic          h_rd [4];
    logic          h_wr [4];
    logic [AW-1:0] h_addr [4];
    logic [BW-1:0] h_be [4];
    logic [DW-1:0] h_dwr [4];
    logic [DW-1:0] d_drd [4];
    logic          d_ack [4];

    logic [AW-1:0] add_bus;
    logic [BW-1:0] byte_en;
    logic          wr_bus, rd_bus, cpu_bus, ack_bus;
    logic [DW-1:0] data_bus_wr, data_bus_rd;

    int n_cmp = 0;
    int n_bad = 0;

    rr_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .mcpu(h_cpu[0]), .maddr(h_addr[0]), .mrd(h_rd[0]), .mwr(h_wr[0]),
        .mbe(h_be[0]), .mdwr(h_dwr[0]), .mdrd(d_drd[0]), .mack(d_ack[0]),
        .scpu(h_cpu[1]), .saddr(h_addr[1]), .srd(h_rd[1]), .swr(h_wr[1]),
        .sbe(h_be[1]), .sdwr(h_dwr[1]), .sdrd(d_drd[1]), .sack(d_ack[1]),
        .tcpu(h_cpu[2]), .taddr(h_addr[2]), .trd(h_rd[2]), .twr(h_wr[2]),
        .tbe(h_be[2]), .tdwr(h_dwr[2]), .tdrd(d_drd[2]), .tack(d_ack[2]),
        .ecpu(h_cpu[3]), .eaddr(h_addr[3]), .erd(h_rd[3]), .ewr(h_wr[3]),
        .ebe(h_be[3]), .edwr(h_dwr[3]), .edrd(d_drd[3]), .eack(d_ack[3]),
        .add_bus(add_bus), .byte_en(byte_en), .wr_bus(wr_bus), .rd_bus(rd_bus),
        .data_bus_wr(data_bus_wr), .data_bus_rd(data_bus_rd),
        .ack_bus(ack_bus), .cpu_bus(cpu_bus)
    );

    typedef struct {
        int            own;
        int            lat;
        logic [DW-1:0] dwr;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_hosts();
        for (int h = 0; h < 4; h++) begin
            h_cpu[h] = 0; h_rd[h] = 0; h_wr[h] = 0;
            h_addr[h] = '0; h_be[h] = '0; h_dwr[h] = '0;
        end
    endtask

    task automatic set_host(int h, bit rd, logic [AW-1:0] a);
        h_cpu[h] = 1; h_rd[h] = rd; h_wr[h] = !rd; h_addr[h] = a;
    endtask

    task automatic do_reset();
        reset_n = 0;
        idle_hosts();
        ack_bus = 0;
        data_bus_rd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        tick();
    endtask

    task automatic chk_zero(string nm);
        chk({nm, ".bus"}, {cpu_bus, rd_bus, wr_bus, byte_en, add_bus, data_bus_wr}, '0);
        chk({nm, ".ack"}, {d_ack[0], d_ack[1], d_ack[2], d_ack[3]}, '0);
        chk({nm, ".drd"}, d_drd[0] | d_drd[1] | d_drd[2] | d_drd[3], '0);
    endtask

    task automatic wait_busy(string nm);
        int i = 0;
        while (!cpu_bus && i < 20) begin
            tick();
            i++;
        end
        chk({nm, ".grant"}, cpu_bus, 1);
    endtask

    task automatic run_random(int ncyc);
        int   last = 3;
        int   owner = 0;
        int   cnt = 0;
        int   lat = 0;
        bit   busy = 0;
        int   waits [4];
        bit   drop [4];
        logic ack;
        logic [DW-1:0] rdat;
        for (int h = 0; h < 4; h++) begin
            waits[h] = 0;
            drop[h] = 0;
        end
        for (int c = 0; c < ncyc; c++) begin
            for (int h = 0; h < 4; h++) begin
                if (drop[h]) begin
                    h_cpu[h] = 0; h_rd[h] = 0; h_wr[h] = 0; drop[h] = 0;
                end else if (!h_cpu[h] && $urandom_range(3) == 0) begin
                    h_cpu[h] = 1;
                    h_rd[h] = 1'($urandom_range(1));
                    h_wr[h] = !h_rd[h] || ($urandom_range(15) == 0);
                    h_addr[h] = $urandom;
                    h_be[h] = 4'($urandom);
                    h_dwr[h] = $urandom;
                end else if (busy && h == owner && $urandom_range(31) == 0) begin
                    h_cpu[h] = 0; h_rd[h] = 0; h_wr[h] = 0;
                end
            end
            rdat = $urandom;
            if (busy) ack = h_cpu[owner] && (cnt >= lat);
            else ack = ($urandom_range(7) == 0);
            ack_bus = ack;
            data_bus_rd = rdat;
            #2;
            chk("rnd.cpu_bus", cpu_bus, busy);
            if (busy) begin
                chk("rnd.addr", add_bus, h_addr[owner]);
                chk("rnd.be_dwr", {byte_en, data_bus_wr}, {h_be[owner], h_dwr[owner]});
                chk("rnd.rdwr", {rd_bus, wr_bus},
                    {h_cpu[owner] & h_rd[owner], h_cpu[owner] & h_wr[owner] & !h_rd[owner]});
            end else begin
                chk("rnd.idlebus", {rd_bus, wr_bus, byte_en, add_bus, data_bus_wr}, '0);
            end
            for (int h = 0; h < 4; h++) begin
                chk("rnd.xack", d_ack[h], busy && h == owner && ack);
                chk("rnd.xdrd", d_drd[h], (busy && h == owner) ? rdat : '0);
            end
            if (busy) begin
                if (ack) begin
                    busy = 0; last = owner; drop[owner] = 1;
                end else if (!h_cpu[owner]) begin
                    busy = 0; last = owner;
                end else begin
                    cnt++;
                end
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    int h;
                    h = (last + k) % 4;
                    if (!busy && h_cpu[h] && (h_rd[h] || h_wr[h])) begin
                        busy = 1; owner = h; cnt = 0;
                        lat = $urandom_range(3);
                    end
                end
                if (busy) begin
                    for (int h = 0; h < 4; h++)
                        if (h != owner && h_cpu[h] && (h_rd[h] || h_wr[h])) waits[h]++;
                    chk("rnd.fair", waits[owner] <= 3, 1);
                    waits[owner] = 0;
                end
            end
            tick();
        end
        ack_bus = 0;
        idle_hosts();
        repeat (3) tick();
    endtask

    initial begin
        tbl[0] = '{own: 0, lat: 1, dwr: 32'hD000_0000, be: 4'b1111, addr: 32'h200};
        tbl[1] = '{own: 1, lat: 0, dwr: 32'hD000_0001, be: 4'b0011, addr: 32'h204};
        tbl[2] = '{own: 2, lat: 2, dwr: 32'hD000_0002, be: 4'b1100, addr: 32'h208};
        tbl[3] = '{own: 3, lat: 1, dwr: 32'hD000_0003, be: 4'b0101, addr: 32'h20C};
        tbl[4] = '{own: 0, lat: 0, dwr: 32'hD000_0000, be: 4'b1111, addr: 32'h200};

        idle_hosts();
        ack_bus = 0;
        data_bus_rd = '0;
        #1;
        chk_zero("rst.during");
        do_reset();
        chk_zero("rst.after");

        // single read from host m
        set_host(0, 1, 32'h100);
        #2;
        chk("t1.latency", cpu_bus, 0);
        tick();
        chk("t1.addr", add_bus, 32'h100);
        chk("t1.rdwr", {rd_bus, wr_bus}, 2'b10);
        tick();
        chk("t1.noack", d_ack[0], 0);
        tick();
        ack_bus = 1;
        data_bus_rd = 32'hA5A5_0001;
        #1;
        chk("t1.mack", d_ack[0], 1);
        chk("t1.mdrd", d_drd[0], 32'hA5A5_0001);
        tick();
        ack_bus = 0;
        idle_hosts();
        #1;
        chk("t1.release", {cpu_bus, d_ack[0]}, 0);

        // four writers, round-robin order from reset
        do_reset();
        for (int h = 0; h < 4; h++) begin
            h_cpu[h] = 1; h_wr[h] = 1;
            h_dwr[h] = 32'(32'hD000_0000 + h);
            h_addr[h] = 32'(32'h200 + 4 * h);
        end
        h_be[0] = 4'b1111; h_be[1] = 4'b0011; h_be[2] = 4'b1100; h_be[3] = 4'b0101;
        for (int v = 0; v < 5; v++) begin
            wait_busy("t2");
            chk("t2.dwr", data_bus_wr, tbl[v].dwr);
            chk("t2.be", byte_en, tbl[v].be);
            chk("t2.addr", add_bus, tbl[v].addr);
            chk("t2.wr", {wr_bus, rd_bus}, 2'b10);
            repeat (tbl[v].lat) tick();
            ack_bus = 1;
            #1;
            chk("t2.ack", {d_ack[0], d_ack[1], d_ack[2], d_ack[3]}, 4'b1000 >> tbl[v].own);
            tick();
            ack_bus = 0;
            h_wr[tbl[v].own] = 0;
            #1;
            chk("t2.gap", cpu_bus, 0);
            tick();
            h_wr[tbl[v].own] = 1;
        end
        idle_hosts();
        ack_bus = 1;
        tick();
        ack_bus = 0;
        tick();

        // host t alone, held request
        set_host(2, 1, 32'h300);
        wait_busy("t3");
        for (int n = 0; n < 3; n++) begin
            chk("t3.addr", add_bus, 32'h300);
            ack_bus = 1;
            data_bus_rd = 32'(n + 7);
            #1;
            chk("t3.tack", {d_ack[2], d_drd[2]}, {1'b1, 32'(n + 7)});
            tick();
            ack_bus = 0;
            if (n == 2) idle_hosts();
            #1;
            chk("t3.gap", cpu_bus, 0);
            tick();
            if (n < 2) chk("t3.regrant", cpu_bus, 1);
        end

        // ack while idle is ignored; isolation while e owns the bus
        ack_bus = 1;
        #1;
        chk_zero("t4.idleack");
        tick();
        ack_bus = 0;
        set_host(3, 0, 32'h400);
        wait_busy("t4");
        data_bus_rd = 32'h1234_5678;
        ack_bus = 1;
        #1;
        chk("t4.eack", {d_ack[3], d_drd[3]}, {1'b1, 32'h1234_5678});
        chk("t4.others", {d_ack[0], d_ack[1], d_ack[2]}, 3'b000);
        chk("t4.odrd", d_drd[0] | d_drd[1] | d_drd[2], '0);
        tick();
        ack_bus = 0;
        idle_hosts();
        tick();

        // async reset in BUSY, then host 0 first
        set_host(1, 1, 32'h510);
        set_host(2, 1, 32'h520);
        wait_busy("t5");
        #2;
        reset_n = 0;
        ack_bus = 1;
        #1;
        chk_zero("t5.rst");
        for (int h = 0; h < 4; h++) set_host(h, 1, 32'(32'h500 + 16 * h));
        @(negedge clk);
        ack_bus = 0;
        reset_n = 1;
        tick();
        wait_busy("t5.post");
        chk("t5.first", add_bus, 32'h500);
        ack_bus = 1;
        tick();
        ack_bus = 0;
        idle_hosts();
        tick();

        // abort by xcpu drop moves the pointer past the aborter
        set_host(1, 1, 32'h600);
        tick();
        chk("t6.addr", add_bus, 32'h600);
        h_cpu[1] = 0;
        set_host(0, 1, 32'h700);
        set_host(2, 1, 32'h720);
        #1;
        chk("t6.gated", {rd_bus, d_ack[1]}, 2'b00);
        tick();
        chk("t6.abort", cpu_bus, 0);
        tick();
        chk("t6.next", add_bus, 32'h720);
        ack_bus = 1;
        tick();
        ack_bus = 0;
        idle_hosts();
        tick();

`ifdef ARB_TIMEOUT_EN
        begin
            int nb = 0;
            do_reset();
            set_host(3, 1, 32'h800);
            wait_busy("t7");
            set_host(0, 1, 32'h810);
            while (!d_ack[3] && nb < 40) begin
                tick();
                nb++;
            end
            chk("t7.cycles", nb, 16);
            chk("t7.drd", d_drd[3], 32'hDEAD_BEEF);
            tick();
            h_cpu[3] = 0; h_rd[3] = 0;
            wait_busy("t7.next");
            chk("t7.nextaddr", add_bus, 32'h810);
            ack_bus = 1;
            tick();
            ack_bus = 0;
            idle_hosts();
            tick();
        end
`endif

        do_reset();
        run_random(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Four-host round-robin bus arbiter between host ports master (m), slave (s), test (t) and extra (e) and a single shared slave bus. It grants one host at a time, muxes that host's request onto the slave bus, and routes the slave's read data and acknowledge back to the granted host only. It sits between the CPU/host ports and the memory-mapped slave fabric.

## Interface
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- BE_W, DATA_W/8, byte-enable width.
- TIMEOUT, 16, cycles to wait for ack_bus before abort (only with ARB_TIMEOUT_EN).
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are `clk` and `reset_n`.
- clk  in  1  clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- Host x = m (host 0), s (host 1), t (host 2), e (host 3). Each host has the following eight ports:
  - xcpu  in  1  host session valid.
  - xaddr  in  ADDR_W  address.
  - xrd  in  1  read request.
  - xwr  in  1  write request.
  - xbe  in  BE_W  byte enables.
  - xdwr  in  DATA_W  write data.
  - xdrd  out  DATA_W  read data.
  - xack  out  1  transfer done.
- add_bus  out  ADDR_W  slave address.
- byte_en  out  BE_W  slave byte enables.
- wr_bus  out  1  slave write strobe.
- rd_bus  out  1  slave read strobe.
- data_bus_wr  out  DATA_W  slave write data.
- data_bus_rd  in  DATA_W  slave read data.
- ack_bus  in  1  slave acknowledge.
- cpu_bus  out  1  bus owned and transfer in progress.

## Operation
- Host i requests when req[i] = xcpu & (xrd | xwr).
- xrd and xwr asserted together is illegal. If it occurs, the transfer is a read.
- State machine: IDLE and BUSY. Registers: grant index g (2 bits) and last-served pointer p (2 bits).
- IDLE: if any req, choose the first requesting host in the order p+1, p+2, p+3, p+4 (mod 4). Then g <= that host and state <= BUSY.
- IDLE with no request: stay in IDLE.
- BUSY: the slave bus outputs equal host g's addr, be and dwr, plus rd/wr gated by its cpu. cpu_bus = 1.
- BUSY: host g's xdrd = data_bus_rd and xack = ack_bus, combinational pass-through.
- Every non-granted host's xdrd and xack are 0.
- BUSY and ack_bus = 1: this is the transfer end. p <= g, state <= IDLE.
- BUSY and granted host drops xcpu before ack_bus: abort. No ack is delivered, p <= g, state <= IDLE.
- Outside BUSY: add_bus, byte_en, wr_bus, rd_bus, data_bus_wr and cpu_bus are all 0.
- Hosts hold addr, be, dwr and rd/wr stable from request until their xack.
- Hosts deassert rd/wr in the cycle after xack. A still-asserted request is treated as a new request.
- Fairness: a continuously requesting host waits at most 3 other transfers.

## Timing
- Reset: state IDLE, p = 3 (host 0 wins first), g = 0. All outputs are 0.
- Reset mid-transfer aborts immediately. The slave sees rd_bus/wr_bus drop asynchronously.
- Grant latency: req sampled high at edge N, then slave bus strobes are valid after edge N (one cycle).
- Ack is combinational. xack is high in exactly the cycles where ack_bus is high while BUSY. A single-cycle ack_bus ends the transfer.
- One mandatory IDLE cycle between transfers. Back-to-back throughput is 1 transfer per (slave latency + 2) cycles.
- Simultaneous requests in IDLE are resolved by round-robin only. There are no fixed priorities.
- ack_bus while IDLE is ignored.

## Configuration
- ARB_TIMEOUT_EN defined: an 8-bit counter clears on entering BUSY and increments each BUSY cycle. If it reaches TIMEOUT without ack_bus:
  - one-cycle xack to host g with xdrd = 32'hDEAD_BEEF;
  - p <= g, state <= IDLE.
- ARB_TIMEOUT_EN undefined: no counter. BUSY waits for ack_bus or an xcpu drop indefinitely.

## Test plan
- Reset, then mcpu=1, mrd=1, maddr=0x100. Slave acks after 2 cycles with data_bus_rd=0xA5A5_0001. Required: add_bus=0x100, rd_bus=1, then mack=1 and mdrd=0xA5A5_0001 for 1 cycle, cpu_bus back to 0.
- All four hosts write simultaneously and continuously. Required: grant order 0,1,2,3,0. Each transfer's data_bus_wr equals the owner's xdwr, and byte_en equals the owner's xbe (e.g. 4'b0011 for host s).
- Only host t requests repeatedly. Required: it is granted every transfer, with the one-cycle IDLE gap between transfers.
- While host e is granted, pulse ack_bus: only eack rises. mack, sack and tack stay 0, and mdrd, sdrd and tdrd stay 0.
- Assert reset_n=0 mid-BUSY. Required: all outputs 0 immediately. After release, host 0 gets the first grant.
- With ARB_TIMEOUT_EN: the slave never acks. Required: xack after 16 BUSY cycles with xdrd=0xDEAD_BEEF, and the next requester is granted.
